cmos_frame_gate: RTL
====================

Name: cmos_frame_gate

Overview:
Downstream of the 8-to-16-bit camera byte packer, on the same pclk domain. Consumes the 16-bit pixel stream plus frame vsync and discards the first SKIP_FRAMES frames while the sensor settles. Then writes only whole, in-window frames (H_ACTIVE x V_ACTIVE) into the async FIFO that feeds the HDMI side. Frames are aligned to vsync, clipped to the window, and dropped on FIFO overflow until the next frame boundary.

Parameters:
SKIP_FRAMES, 10, frames discarded after reset before the first write (0 = write from the first boundary)
H_ACTIVE, 800, pixels written per line; extra pixels are clipped
V_ACTIVE, 480, lines written per frame; extra lines are clipped
VS_POL, 1, active level of vsync_i (1 = high pulse between frames)

Ports:
pclk  in  1  pixel clock, sole clock
rst_n  in  1  asynchronous active-low reset
vsync_i  in  1  camera frame sync, already on pclk
de_i  in  1  16-bit pixel valid from packer
pdata_i  in  16  pixel data, valid when de_i
fifo_full_i  in  1  write-side full flag of the frame FIFO
fifo_wr_en  out  1  FIFO write strobe
fifo_wr_data  out  16  FIFO write data
frame_start  out  1  one-cycle pulse at an accepted frame boundary
frame_done  out  1  one-cycle pulse on the write of pixel (H_ACTIVE-1, V_ACTIVE-1)
overflow  out  1  sticky per frame; set on a pixel lost to fifo_full_i
active  out  1  high once the skip phase is over

Behaviour:
- Reset (async assert, sync release): state S_SKIP; all counters 0; every output 0.
- Frame boundary (fb): registered vsync_i leaving its active level (falling edge when VS_POL=1). Detection costs one register stage.
- States:
  - S_SKIP: count fb. When SKIP_FRAMES boundaries have been seen, go to S_WAIT. With SKIP_FRAMES=0, go straight to S_WAIT.
  - S_WAIT: on fb -> S_ACTIVE, pulse frame_start, clear x/y/overflow.
  - S_ACTIVE: write pixels. On fb -> restart a new frame (as in S_WAIT), including after a short frame.
  - S_DROP: no writes; on fb -> S_ACTIVE with frame_start.
- Pixel path:
  - In S_ACTIVE with de_i=1, x<H_ACTIVE and y<V_ACTIVE, the next cycle has fifo_wr_en=1 and fifo_wr_data=pdata_i. Latency is exactly 1 cycle.
  - x increments on every de_i regardless of clipping; it saturates at H_ACTIVE.
  - Line end is a de_i falling edge: x<=0, and y increments (saturating at V_ACTIVE) if x!=0.
- Overflow:
  - If fifo_full_i=1 on a cycle that would write, suppress the write, set overflow, go to S_DROP.
  - overflow holds until the next frame_start.
- frame_done:
  - Asserts on the same cycle as the final window write. Then move to S_WAIT; the remaining pixels of that frame are ignored.
- active: 0 in S_SKIP, 1 otherwise.
- Simultaneous events:
  - fb and de_i on the same cycle: fb wins and the pixel is discarded.
  - fifo_full_i while not writing has no effect.
- vsync_i held active forever: the block stays in its current wait state, with no writes.
- Reset mid-frame: all outputs drop to 0 asynchronously. The skip count restarts from zero.

Optional Feature:
CMOS_FRAME_STATS_EN.
- Defined: adds outputs line_len_o[11:0] and line_cnt_o[11:0]. Each is latched at every fb from raw, unclipped counters: the last line's pixel count and the frame's line count.
  - The raw counters saturate at 4095.
  - Both reset to 0.
  - Used for sensor-mode bring-up.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
Shared package holds:
- State encoding localparams S_SKIP/S_WAIT/S_ACTIVE/S_DROP.
- Counter width constant CNT_W=12.

One natural sub-module, cmos_edge_det: registered rising/falling edge detector, instantiated for vsync (with VS_POL inversion) and de_i.

Test Plan:
- SKIP_FRAMES=2, H=4, V=2, ideal 4x2 frames -> no writes for frames 1-2. Frame 3: frame_start, then 8 writes of data 0x0000..0x0007, frame_done on the 8th write.
- Lines of 6 pixels with H_ACTIVE=4 -> only pixels 0-3 of each line are written; pixels 4-5 are never written.
- fifo_full_i=1 for one cycle at pixel 3 of line 0 -> that pixel is not written, overflow=1, no further writes. At the next fb: frame_start, overflow=0, writes resume.
- Short frame: fb after 1 of 2 lines -> no frame_done. The next frame restarts at x=y=0 with frame_start.
- Reset pulse mid-line in S_ACTIVE -> fifo_wr_en=0 immediately, active=0. The next SKIP_FRAMES frames are dropped.
- CMOS_FRAME_STATS_EN defined, frame of 3 lines x 5 pixels -> at fb: line_len_o=5, line_cnt_o=3.

Source files
------------

// File: rtl/cmos_frame_gate_pkg.sv
// Shared types and helpers for the camera frame gate.
// Holds the FSM state encoding and the common counter width.
package cmos_frame_gate_pkg;

    localparam int CNT_W = 12;

    typedef enum logic [1:0] {
        S_SKIP   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACTIVE = 2'd2,
        S_DROP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Increment that sticks at lim instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v < lim) ? v + CNT_W'(1) : lim;
    endfunction

endpackage

// File: rtl/cmos_frame_gate_edge_det.sv
// Registered rising/falling edge detector with optional input inversion.
// Edge pulses appear one cycle after the input changes level.
module cmos_edge_det #(
    parameter bit INV = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_n;
    logic sig_q;

    assign sig_n = sig ^ INV;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sig_q <= sig_n;
            rise  <= sig_n & ~sig_q;
            fall  <= ~sig_n & sig_q;
        end
    end

endmodule

// File: rtl/cmos_frame_gate.sv
// Frame gate between the camera byte packer and the HDMI frame FIFO.
// Define CMOS_FRAME_STATS_EN to add the raw line length / line count outputs.
//
// state    | meaning
// S_SKIP   | discarding settle frames, counting frame boundaries
// S_WAIT   | waiting for a frame boundary to start writing
// S_ACTIVE | writing in-window pixels of the current frame
// S_DROP   | frame lost to FIFO overflow, waiting for next boundary
module cmos_frame_gate
    import cmos_frame_gate_pkg::*;
#(
    parameter int SKIP_FRAMES = 10,
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 480,
    parameter bit VS_POL      = 1'b1
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             vsync_i,
    input  logic             de_i,
    input  logic [15:0]      pdata_i,
    input  logic             fifo_full_i,
    output logic             fifo_wr_en,
    output logic [15:0]      fifo_wr_data,
    output logic             frame_start,
    output logic             frame_done,
    output logic             overflow,
`ifdef CMOS_FRAME_STATS_EN
    output logic [CNT_W-1:0] line_len_o,
    output logic [CNT_W-1:0] line_cnt_o,
`endif
    output logic             active
);

    localparam logic [CNT_W-1:0] H_LIM     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_LIM     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);
    localparam bit               SKIP_NONE = (SKIP_FRAMES == 0);

    state_t           state;
    state_t           state_nxt;
    logic             fb;
    logic             line_end;
    logic             vs_rise;
    logic             de_rise;
    logic             unused_rise;
    logic [CNT_W-1:0] skip_cnt;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic [CNT_W-1:0] x_eff;
    logic [CNT_W-1:0] y_eff;
    logic             in_win;
    logic             want_wr;
    logic             wr_now;
    logic             ovf_now;
    logic             done_now;
    logic             start_now;

    // Normalise vsync so its inactive transition is always the falling edge.
    cmos_edge_det #(.INV(VS_POL == 1'b0)) u_vs_edge (
        .clk   (pclk),
        .rst_n (rst_n),
        .sig   (vsync_i),
        .rise  (vs_rise),
        .fall  (fb)
    );

    cmos_edge_det #(.INV(1'b0)) u_de_edge (
        .clk   (pclk),
        .rst_n (rst_n),
        .sig   (de_i),
        .rise  (de_rise),
        .fall  (line_end)
    );

    assign unused_rise = vs_rise ^ de_rise;

    // Line end and a new pixel may land on the same cycle, so position uses the post-line-end view.
    always_comb begin
        x_eff = line_end ? '0 : x;
        y_eff = (line_end && x != '0) ? sat_inc(y, V_LIM) : y;
    end

    assign in_win = de_i && (x_eff < H_LIM) && (y_eff < V_LIM);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_SKIP;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_now = 1'b0;
        want_wr   = (state == S_ACTIVE) && !fb && in_win;
        wr_now    = want_wr && !fifo_full_i;
        ovf_now   = want_wr && fifo_full_i;
        done_now  = wr_now && (x_eff == H_LAST) && (y_eff == V_LAST);
        case (state)
            S_SKIP: begin
                if (SKIP_NONE || (fb && skip_cnt == SKIP_LAST)) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT, S_DROP: begin
                if (fb) begin
                    state_nxt = S_ACTIVE;
                    start_now = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (fb) begin
                    state_nxt = S_ACTIVE;
                    start_now = 1'b1;
                end else if (ovf_now) begin
                    state_nxt = S_DROP;
                end else if (done_now) begin
                    state_nxt = S_WAIT;
                end
            end
            default: state_nxt = S_SKIP;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            skip_cnt <= '0;
        end else if (state == S_SKIP && fb) begin
            skip_cnt <= skip_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (fb) begin
            x <= '0;
            y <= '0;
        end else begin
            x <= de_i ? sat_inc(x_eff, H_LIM) : x_eff;
            y <= y_eff;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            fifo_wr_en  <= wr_now;
            frame_start <= start_now;
            frame_done  <= done_now;
            if (wr_now) begin
                fifo_wr_data <= pdata_i;
            end
            if (start_now) begin
                overflow <= 1'b0;
            end else if (ovf_now) begin
                overflow <= 1'b1;
            end
        end
    end

    assign active = (state != S_SKIP);

`ifdef CMOS_FRAME_STATS_EN
    logic [CNT_W-1:0] raw_x;
    logic [CNT_W-1:0] raw_y;
    logic [CNT_W-1:0] last_len;
    logic [CNT_W-1:0] raw_x_eff;
    logic [CNT_W-1:0] raw_y_eff;
    logic [CNT_W-1:0] last_len_eff;

    always_comb begin
        raw_x_eff    = line_end ? '0 : raw_x;
        raw_y_eff    = raw_y;
        last_len_eff = last_len;
        if (line_end && raw_x != '0) begin
            raw_y_eff    = sat_inc(raw_y, CNT_MAX);
            last_len_eff = raw_x;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            raw_x      <= '0;
            raw_y      <= '0;
            last_len   <= '0;
            line_len_o <= '0;
            line_cnt_o <= '0;
        end else if (fb) begin
            line_len_o <= last_len_eff;
            line_cnt_o <= raw_y_eff;
            raw_x      <= '0;
            raw_y      <= '0;
            last_len   <= '0;
        end else begin
            raw_x    <= de_i ? sat_inc(raw_x_eff, CNT_MAX) : raw_x_eff;
            raw_y    <= raw_y_eff;
            last_len <= last_len_eff;
        end
    end
`endif

endmodule
